// File: rtl/mmio_console_pkg.sv
// Register map and status bit layout shared by the mmio_console block.
package mmio_console_pkg;

  localparam logic [31:0] END_ADDR     = 32'h000;
  localparam logic [31:0] STATUS_ADDR  = 32'h004;
  localparam logic [31:0] CH_BASE_ADDR = 32'h100;
  localparam logic [31:0] CH_STRIDE    = 32'h010;

  localparam logic [3:0] TXDATA_OFF    = 4'h0;
  localparam logic [3:0] CH_STATUS_OFF = 4'h4;
  localparam logic [3:0] CTRL_OFF      = 4'h8;

  localparam int STATUS_HALT_BIT = 0;
  localparam int STATUS_CODE_LSB = 8;
  localparam int STATUS_NE_LSB   = 16;

  localparam int CHS_EMPTY_BIT = 16;
  localparam int CHS_FULL_BIT  = 17;
  localparam int CHS_OVF_BIT   = 18;

  localparam int CTRL_CLR_OVF_BIT = 0;
  localparam int CTRL_FLUSH_BIT   = 1;

endpackage

// File: rtl/mmio_byte_fifo.sv
// Byte FIFO for one console channel; a push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle. Flush beats push and pop.
module mmio_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [7:0]               data_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [7:0]               head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = DEPTH[PW:0];

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW:0]   count_q, count_d;
  logic [7:0]    mem_q [DEPTH];
  logic          doPush, doPop;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];
  assign doPop   = pop_i && !empty_o;
  assign doPush  = push_i && (!full_o || doPop);

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({doPush, doPop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count is non-zero.
  always_ff @(posedge clk) begin
    if (doPush && !flush_i && !rst_i) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped multi-channel console plus END/halt register.
// Optional MMIO_CONSOLE_SIM_PRINT_EN echoes popped bytes and ends simulation on halt.
module mmio_console
  import mmio_console_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 12
) (
  input  logic               clk,
  input  logic               sys_reset_i,
  input  logic               en_i,
  input  logic [3:0]         we_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic [NCH-1:0]     tx_valid_o,
  output logic [NCH*8-1:0]   tx_data_o,
  input  logic [NCH-1:0]     tx_ready_i,
  output logic               halt_o,
  output logic [7:0]         exit_code_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]    addrW;
  logic [3:0]     chIdx;
  logic [3:0]     chOff;
  logic           isCh;
  logic           wrEn, rdEn;

  logic [CW-1:0]  count [NCH];
  logic [7:0]     head  [NCH];
  logic [NCH-1:0] full, empty, txValid, push, pop, flush;
  logic [NCH-1:0] ovf_q, ovf_d;
  logic           halt_q, halt_d;
  logic [7:0]     exitCode_q, exitCode_d;
  logic [31:0]    data_q, data_d, rdVal;
  logic           unusedBits;

  assign unusedBits = ^{addr_i[1:0], data_i[31:8]};

  assign addrW = 32'({addr_i[ADDR_W-1:2], 2'b00});
  assign chIdx = 4'((addrW - CH_BASE_ADDR) >> 4);
  assign chOff = addrW[3:0];
  assign isCh  = (addrW >= CH_BASE_ADDR) && (addrW < CH_BASE_ADDR + 32'(NCH) * CH_STRIDE);
  assign wrEn  = en_i && (we_i != 4'b0);
  assign rdEn  = en_i && (we_i == 4'b0);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic chSel;
    assign chSel = wrEn && isCh && (chIdx == 4'(c));
    // Pushes are silently dropped once halted; draining still proceeds.
    assign push[c]    = chSel && (chOff == TXDATA_OFF) && !halt_q;
    assign flush[c]   = chSel && (chOff == CTRL_OFF) && data_i[CTRL_FLUSH_BIT];
    assign pop[c]     = txValid[c] && tx_ready_i[c];
    assign txValid[c] = !empty[c];
    assign tx_data_o[8*c +: 8] = head[c];

    always_comb begin
      ovf_d[c] = ovf_q[c];
      if (chSel && (chOff == CTRL_OFF) && data_i[CTRL_CLR_OVF_BIT]) ovf_d[c] = 1'b0;
      if (push[c] && full[c] && !pop[c]) ovf_d[c] = 1'b1;
    end

    mmio_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst_i   (sys_reset_i),
      .push_i  (push[c]),
      .pop_i   (pop[c]),
      .flush_i (flush[c]),
      .data_i  (data_i[7:0]),
      .count_o (count[c]),
      .full_o  (full[c]),
      .empty_o (empty[c]),
      .head_o  (head[c])
    );
  end

  always_comb begin
    halt_d     = halt_q;
    exitCode_d = exitCode_q;
    if (wrEn && (addrW == END_ADDR) && !halt_q) begin
      halt_d     = 1'b1;
      exitCode_d = data_i[7:0];
    end
  end

  always_comb begin
    rdVal = '0;
    if (addrW == STATUS_ADDR) begin
      rdVal[STATUS_HALT_BIT]       = halt_q;
      rdVal[STATUS_CODE_LSB +: 8]  = exitCode_q;
      rdVal[STATUS_NE_LSB +: NCH]  = txValid;
    end else if (isCh && (chOff == CH_STATUS_OFF)) begin
      for (int c = 0; c < NCH; c++) begin
        if (chIdx == 4'(c)) begin
          rdVal[15:0]          = 16'(count[c]);
          rdVal[CHS_EMPTY_BIT] = empty[c];
          rdVal[CHS_FULL_BIT]  = full[c];
          rdVal[CHS_OVF_BIT]   = ovf_q[c];
        end
      end
    end
  end

  assign data_d = rdEn ? rdVal : 32'h0;

  always_ff @(posedge clk) begin
    if (sys_reset_i) begin
      ovf_q      <= '0;
      halt_q     <= 1'b0;
      exitCode_q <= 8'h00;
      data_q     <= 32'h0;
    end else begin
      ovf_q      <= ovf_d;
      halt_q     <= halt_d;
      exitCode_q <= exitCode_d;
      data_q     <= data_d;
    end
  end

  assign data_o      = data_q;
  assign tx_valid_o  = txValid;
  assign halt_o      = halt_q;
  assign exit_code_o = exitCode_q;

`ifdef MMIO_CONSOLE_SIM_PRINT_EN
  always @(posedge clk) begin
    if (!sys_reset_i) begin
      for (int c = 0; c < NCH; c++) begin
        if (pop[c]) begin
          $write("%c", head[c]);
        end
      end
      // Ends only after every channel has drained.
      if (halt_q && (txValid == '0)) begin
        $display("# %0t END OF SIMULATION exit=%0d", $time, exitCode_q);
        $finish;
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_mmio_console.sv
// Directed self-checking bench for mmio_console (default build, NCH=2, DEPTH=16).
module tb_mmio_console;

  localparam int NCH    = 2;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              sysReset;
  logic              en;
  logic [3:0]        we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       dataIn;
  logic [31:0]       dataOut;
  logic [NCH-1:0]    txValid;
  logic [NCH*8-1:0]  txData;
  logic [NCH-1:0]    txReady;
  logic              halt;
  logic [7:0]        exitCode;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;

  mmio_console #(.NCH(NCH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .sys_reset_i (sysReset),
    .en_i        (en),
    .we_i        (we),
    .addr_i      (addr),
    .data_i      (dataIn),
    .data_o      (dataOut),
    .tx_valid_o  (txValid),
    .tx_data_o   (txData),
    .tx_ready_i  (txReady),
    .halt_o      (halt),
    .exit_code_o (exitCode)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle; returns 1 time unit after the edge with the bus idle.
  task automatic applyStimulus(input logic [3:0] weV, input logic [11:0] a, input logic [31:0] d);
    en = 1'b1; we = weV; addr = a; dataIn = d;
    @(posedge clk); #1;
    en = 1'b0; we = 4'h0; addr = '0; dataIn = '0;
  endtask

  task automatic busRead(input logic [11:0] a, output logic [31:0] v);
    applyStimulus(4'h0, a, 32'h0);
    v = dataOut;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    sysReset = 1'b1; en = 1'b0; we = 4'h0; addr = '0; dataIn = '0; txReady = '0;
    tick(); tick(); tick();
    sysReset = 1'b0;

    // Reset state
    checkOutput("rst_valid", 32'(txValid), 32'h0);
    checkOutput("rst_halt", 32'(halt), 32'h0);
    checkOutput("rst_exit", 32'(exitCode), 32'h0);
    checkOutput("rst_data", dataOut, 32'h0);
    busRead(12'h004, rd); checkOutput("rst_status", rd, 32'h0000_0000);
    busRead(12'h104, rd); checkOutput("rst_chstat0", rd, 32'h0001_0000);

    // Basic push and drain on channel 0
    applyStimulus(4'hF, 12'h100, 32'h41);
    checkOutput("valid_after_push", 32'(txValid), 32'h1);
    applyStimulus(4'h1, 12'h100, 32'hFFFF_FF42);
    applyStimulus(4'hF, 12'h100, 32'h43);
    busRead(12'h104, rd); checkOutput("ch0_count3", rd, 32'h0000_0003);
    txReady[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("ch0_drain_valid", 32'(txValid[0]), 32'h1);
      checkOutput("ch0_drain_byte", 32'(txData[7:0]), 32'h41 + 32'(i));
      tick();
    end
    checkOutput("ch0_drained", 32'(txValid), 32'h0);
    txReady[0] = 1'b0;

    // Overflow on channel 1
    for (int i = 0; i < 17; i++) applyStimulus(4'hF, 12'h110, 32'h60 + 32'(i));
    busRead(12'h114, rd); checkOutput("ch1_overflow", rd, 32'h0006_0010);
    applyStimulus(4'hF, 12'h118, 32'h1);
    busRead(12'h114, rd); checkOutput("ch1_ovf_clear", rd, 32'h0002_0010);
    busRead(12'h004, rd); checkOutput("status_ne1", rd, 32'h0002_0000);
    txReady[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput("ch1_drain_byte", 32'(txData[15:8]), 32'h60 + 32'(i));
      tick();
    end
    checkOutput("ch1_17th_absent", 32'(txValid), 32'h0);
    txReady[1] = 1'b0;

    // Move pointers off zero, then fill and push+pop while full across wrap
    for (int i = 0; i < 3; i++) applyStimulus(4'hF, 12'h110, 32'h01 + 32'(i));
    txReady[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("ch1_pre_byte", 32'(txData[15:8]), 32'h01 + 32'(i));
      tick();
    end
    txReady[1] = 1'b0;
    for (int i = 0; i < 16; i++) applyStimulus(4'hF, 12'h110, 32'h80 + 32'(i));
    busRead(12'h114, rd); checkOutput("ch1_full", rd, 32'h0002_0010);
    txReady[1] = 1'b1;
    applyStimulus(4'hF, 12'h110, 32'h90);
    txReady[1] = 1'b0;
    busRead(12'h114, rd); checkOutput("ch1_full_pushpop", rd, 32'h0002_0010);
    txReady[1] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput("ch1_wrap_byte", 32'(txData[15:8]), 32'h81 + 32'(i));
      tick();
    end
    checkOutput("ch1_wrap_drained", 32'(txValid), 32'h0);
    txReady[1] = 1'b0;

    // Halt
    applyStimulus(4'hF, 12'h000, 32'h2A);
    checkOutput("halt_set", 32'(halt), 32'h1);
    checkOutput("exit_set", 32'(exitCode), 32'h2A);
    busRead(12'h004, rd); checkOutput("status_halt", rd, 32'h0000_2A01);
    applyStimulus(4'hF, 12'h000, 32'h05);
    checkOutput("exit_sticky", 32'(exitCode), 32'h2A);
    applyStimulus(4'hF, 12'h100, 32'h55);
    busRead(12'h104, rd); checkOutput("push_after_halt", rd, 32'h0001_0000);

    // Reset clears halt
    sysReset = 1'b1; tick(); sysReset = 1'b0;
    checkOutput("rst2_halt", 32'(halt), 32'h0);
    checkOutput("rst2_exit", 32'(exitCode), 32'h0);

    // Flush concurrent with pop
    for (int i = 0; i < 5; i++) applyStimulus(4'hF, 12'h100, 32'hC0 + 32'(i));
    busRead(12'h104, rd); checkOutput("ch0_count5", rd, 32'h0000_0005);
    txReady[0] = 1'b1;
    applyStimulus(4'hF, 12'h108, 32'h2);
    txReady[0] = 1'b0;
    checkOutput("flush_valid", 32'(txValid), 32'h0);
    busRead(12'h104, rd); checkOutput("flush_chstat", rd, 32'h0001_0000);
    busRead(12'h108, rd); checkOutput("ctrl_read_zero", rd, 32'h0);
    busRead(12'h208, rd); checkOutput("unmapped_read", rd, 32'h0);

    // Reset mid-drain with halt set and a read in flight
    for (int i = 0; i < 4; i++) applyStimulus(4'hF, 12'h100, 32'hA0 + 32'(i));
    applyStimulus(4'hF, 12'h110, 32'hB0);
    applyStimulus(4'hF, 12'h110, 32'hB1);
    applyStimulus(4'hF, 12'h000, 32'h07);
    checkOutput("halt2_set", 32'(halt), 32'h1);
    txReady = 2'b11;
    tick();
    checkOutput("middrain_byte0", 32'(txData[7:0]), 32'hA1);
    sysReset = 1'b1; en = 1'b1; we = 4'h0; addr = 12'h004;
    tick();
    checkOutput("rst3_data", dataOut, 32'h0);
    checkOutput("rst3_valid", 32'(txValid), 32'h0);
    checkOutput("rst3_halt", 32'(halt), 32'h0);
    checkOutput("rst3_exit", 32'(exitCode), 32'h0);
    sysReset = 1'b0; en = 1'b0; addr = '0; txReady = '0;
    busRead(12'h104, rd); checkOutput("rst3_chstat0", rd, 32'h0001_0000);
    busRead(12'h114, rd); checkOutput("rst3_chstat1", rd, 32'h0001_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
